// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle for the IF/ID instruction queue.
// The master side is the fetch/decode/hazard logic; the slave side is the queue.
interface if_id_queue_if #(
    parameter int unsigned DPW = 32
);
    logic [DPW-1:0] PCF;
    logic [DPW-1:0] InstrF;
    logic           validF;
    logic           fullF;
    logic           stallD;
    logic           flushD;
    logic           validD;
    logic [DPW-1:0] InstrD;
    logic [DPW-1:0] PCD;
    logic [DPW-1:0] PCPlus4D;

    modport master (
        output PCF, InstrF, validF, stallD, flushD,
        input  fullF, validD, InstrD, PCD, PCPlus4D
    );

    modport slave (
        input  PCF, InstrF, validF, stallD, flushD,
        output fullF, validD, InstrD, PCD, PCPlus4D
    );
endinterface

// File: rtl/if_id_queue.sv
// In-order instruction buffer between fetch and decode holding {PC, PC+4, instr}.
// Head outputs are combinational from storage and masked to NOP/0/0 when empty.
module if_id_queue #(
    parameter int unsigned    DEPTH = 4,
    parameter int unsigned    DPW   = 32,
    parameter logic [DPW-1:0] NOP   = DPW'(32'h0000_0013)
) (
    input  logic          clk,
    input  logic          rst,
    if_id_queue_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DPW-1:0] pc_mem    [DEPTH];
    logic [DPW-1:0] pc4_mem   [DEPTH];
    logic [DPW-1:0] instr_mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic full;
    logic valid;
    logic push;
    logic pop;

    // Full comes from the registered count only, so stallD never reaches fullF.
    assign full  = (count == CW'(DEPTH));
    assign valid = (count != '0);
    assign push  = bus.validF & ~full & ~bus.flushD;
    assign pop   = valid & ~bus.stallD & ~bus.flushD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flushD) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= bus.PCF;
            pc4_mem[wr_ptr]   <= bus.PCF + DPW'(4);
            instr_mem[wr_ptr] <= bus.InstrF;
        end
    end

    always_comb begin
        bus.fullF    = full;
        bus.validD   = valid;
        bus.InstrD   = NOP;
        bus.PCD      = '0;
        bus.PCPlus4D = '0;
        if (valid) begin
            bus.InstrD   = instr_mem[rd_ptr];
            bus.PCD      = pc_mem[rd_ptr];
            bus.PCPlus4D = pc4_mem[rd_ptr];
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: a queue-based reference model predicts occupancy
// and head contents; a negedge monitor compares the DUT head against the model.
module tb_if_id_queue;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    if_id_queue_if #(.DPW(32)) bus ();

    if_id_queue #(
        .DEPTH (DEPTH),
        .DPW   (32),
        .NOP   (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    entry_t exp_q[$];
    logic   exp_full   = 1'b0;
    logic   exp_valid  = 1'b0;
    logic   pend_flush = 1'b0;
    int     n_vec      = 0;
    int     n_err      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; the model decides what the next edge does.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic stall, input logic flush);
        entry_t e;
        @(posedge clk);
        #1;
        if (pend_flush) exp_q.delete();
        bus.validF = v;
        bus.PCF    = pc;
        bus.InstrF = instr;
        bus.stallD = stall;
        bus.flushD = flush;
        exp_full   = (exp_q.size() == DEPTH);
        exp_valid  = (exp_q.size() != 0);
        pend_flush = flush;
        if (v && !exp_full && !flush) begin
            e.pc    = pc;
            e.pc4   = pc + 32'd4;
            e.instr = instr;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("fullF", {31'b0, bus.fullF}, {31'b0, exp_full});
                chk("validD", {31'b0, bus.validD}, {31'b0, exp_valid});
                if (bus.validD) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL head_unexpected: got PCD %08h, expected no entry at %0t",
                                 bus.PCD, $time);
                    end else begin
                        chk("PCD", bus.PCD, exp_q[0].pc);
                        chk("PCPlus4D", bus.PCPlus4D, exp_q[0].pc4);
                        chk("InstrD", bus.InstrD, exp_q[0].instr);
                        if (!bus.stallD && !bus.flushD) void'(exp_q.pop_front());
                    end
                end else begin
                    chk("InstrD_empty", bus.InstrD, NOP);
                    chk("PCD_empty", bus.PCD, 32'h0);
                    chk("PCPlus4D_empty", bus.PCPlus4D, 32'h0);
                end
            end
        end
    end

    initial begin : stimulus
        bus.validF = 1'b0;
        bus.PCF    = '0;
        bus.InstrF = '0;
        bus.stallD = 1'b0;
        bus.flushD = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // In-order stream with PC+4 generation
        cycle(1'b1, 32'h0, 32'h0050_0093, 1'b0, 1'b0);
        cycle(1'b1, 32'h4, 32'h00A0_0113, 1'b0, 1'b0);
        cycle(1'b1, 32'h8, 32'h0020_81B3, 1'b0, 1'b0);
        idle(4);

        // Fill under stall: fifth push is dropped, then drain
        for (int unsigned i = 0; i < 5; i++)
            cycle(1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle(6);

        // Flush with a simultaneous push, then a lone push
        for (int unsigned i = 0; i < 3; i++)
            cycle(1'b1, 32'h200 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b1, 1'b0);
        cycle(1'b1, 32'h20C, 32'hB000_00FF, 1'b1, 1'b1);
        cycle(1'b1, 32'h300, 32'hC000_0001, 1'b0, 1'b0);
        idle(3);

        // Full queue with pop and push in the same cycle
        for (int unsigned i = 0; i < 4; i++)
            cycle(1'b1, 32'h400 + 32'(4 * i), 32'hD000_0000 + 32'(i), 1'b1, 1'b0);
        cycle(1'b1, 32'h410, 32'hD000_0004, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle(6);

        // Pointer and PC wrap
        for (int unsigned i = 0; i < 10; i++)
            cycle(1'b1, 32'hFFFF_FFE8 + 32'(4 * i), 32'hE000_0000 + 32'(i), 1'b0, 1'b0);
        idle(4);

        // Asynchronous reset mid-cycle with three entries queued
        for (int unsigned i = 0; i < 3; i++)
            cycle(1'b1, 32'h500 + 32'(4 * i), 32'hF000_0000 + 32'(i), 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst        = 1'b1;
        bus.validF = 1'b0;
        bus.stallD = 1'b0;
        #1;
        chk("rst_validD", {31'b0, bus.validD}, 32'h0);
        chk("rst_fullF", {31'b0, bus.fullF}, 32'h0);
        chk("rst_InstrD", bus.InstrD, NOP);
        chk("rst_PCD", bus.PCD, 32'h0);
        chk("rst_PCPlus4D", bus.PCPlus4D, 32'h0);
        exp_q.delete();
        exp_full   = 1'b0;
        exp_valid  = 1'b0;
        pend_flush = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Randomized traffic
        for (int unsigned i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                  $urandom & 32'hFFFF_FFFC,
                  $urandom,
                  ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
